// File: rtl/touch_key_decode.sv
// Touch-screen key decoder: maps registered {x,y} touch words onto a fixed key grid and
// emits debounced press/release pulses, a held level and the accepted key code.
module touch_key_decode #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int GRID_X0    = 0,
    parameter int GRID_Y0    = 0,
    parameter int KEY_W      = 200,
    parameter int KEY_H      = 160,
    parameter int COLS       = 4,
    parameter int ROWS       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    output logic [7:0]  key_code,
    output logic        key_press,
    output logic        key_release,
    output logic        key_held,
    output logic        busy
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [15:0]       X0       = 16'(GRID_X0);
    localparam logic [15:0]       Y0       = 16'(GRID_Y0);
    localparam logic [15:0]       KW       = 16'(KEY_W);
    localparam logic [15:0]       KH       = 16'(KEY_H);
    localparam logic [3:0]        NCOL     = 4'(COLS);
    localparam logic [3:0]        NROW     = 4'(ROWS);
    localparam logic [7:0]        NCOL8    = 8'(COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCATE,
        S_DEBOUNCE,
        S_PRESSED,
        S_OUTSIDE
    } state_t;

    state_t            r_state, w_state_next;
    logic [31:0]       r_data;
    logic [15:0]       r_xr, r_yr;
    logic [3:0]        r_col, r_row;
    logic              r_oog;
    logic [7:0]        r_cand;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_key_code;
    logic              r_press, r_release, r_held;

    logic [15:0]       w_x, w_y;
    logic              w_x_step, w_y_step;
    logic [7:0]        w_cand_code;
    logic              w_start, w_latch, w_press, w_release, w_cnt_clr, w_cnt_inc;

    assign w_x         = r_data[31:16];
    assign w_y         = r_data[15:0];
    assign w_x_step    = (r_xr >= KW) && (r_col < NCOL);
    assign w_y_step    = (r_yr >= KH) && (r_row < NROW);
    assign w_cand_code = {4'd0, r_row} * NCOL8 + {4'd0, r_col};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_latch      = 1'b0;
        w_press      = 1'b0;
        w_release    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_data != 32'd0) begin
                    w_start      = 1'b1;
                    w_state_next = S_LOCATE;
                end
            end
            S_LOCATE: begin
                if (!w_x_step && !w_y_step) begin
                    w_cnt_clr = 1'b1;
                    if (r_col == NCOL || r_row == NROW || r_oog) begin
                        w_state_next = S_OUTSIDE;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = S_DEBOUNCE;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (r_data == 32'd0) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == DEB_LAST) begin
                    w_press      = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_PRESSED;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_PRESSED, S_OUTSIDE: begin
                // Both wait for an unbroken run of no-touch samples; any touch restarts the run.
                if (r_data != 32'd0) begin
                    w_cnt_clr = 1'b1;
                end else if (r_cnt == DEB_LAST) begin
                    w_release    = (r_state == S_PRESSED);
                    w_cnt_clr    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_xr       <= '0;
            r_yr       <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_oog      <= 1'b0;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_key_code <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_data <= data;

            if (w_start) begin
                r_xr  <= w_x - X0;
                r_yr  <= w_y - Y0;
                r_col <= '0;
                r_row <= '0;
                r_oog <= (w_x < X0) || (w_y < Y0);
            end else if (r_state == S_LOCATE) begin
                if (w_x_step) begin
                    r_xr  <= r_xr - KW;
                    r_col <= r_col + 4'd1;
                end
                if (w_y_step) begin
                    r_yr  <= r_yr - KH;
                    r_row <= r_row + 4'd1;
                end
            end

            if (w_latch) r_cand <= w_cand_code;

            if (w_cnt_clr)      r_cnt <= '0;
            else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);

            r_press   <= w_press;
            r_release <= w_release;
            if (w_press) begin
                r_key_code <= r_cand;
                r_held     <= 1'b1;
            end else if (w_release) begin
                r_held <= 1'b0;
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_held    = r_held;
    assign busy        = (r_state != S_IDLE);

endmodule
